tlul_req_master: RTL and testbench

TLUL_REQ_MASTER -- requirements
Module: tlul_req_master

---
 rtl/tlul_pkg.sv | 26 ++
 rtl/tlul_req_master.sv | 184 ++++++++++++++++++
 tb/tb_tlul_req_master.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions: channel opcodes, request-master FSM encoding and
// the A-channel opcode selection rule.
package tlul_pkg;

    localparam logic [2:0] TL_PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] TL_GET              = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK       = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA  = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_A_REQ  = 2'd1,
        ST_D_WAIT = 2'd2,
        ST_RSP    = 2'd3
    } tlul_state_e;

    // A write with any byte disabled (including none) must go out as a partial put.
    function automatic logic [2:0] a_opcode(input logic we, input logic be_full);
        if (!we) begin
            return TL_GET;
        end
        return be_full ? TL_PUT_FULL_DATA : TL_PUT_PARTIAL_DATA;
    endfunction

endpackage

// File: rtl/tlul_req_master.sv
// Single-outstanding TL-UL host master: captures one host request, issues it on
// the A channel, waits (with optional timeout) for the D response, returns it.
module tlul_req_master
    import tlul_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int SOURCE_W  = 8,
    parameter int SOURCE_ID = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [DATA_W-1:0]   i_req_wdata,
    input  logic [DATA_W/8-1:0] i_req_be,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_rsp_err,
    output logic                o_rsp_timeout,
    output logic                o_a_valid,
    input  logic                i_a_ready,
    output logic [2:0]          o_a_opcode,
    output logic [2:0]          o_a_param,
    output logic [2:0]          o_a_size,
    output logic [SOURCE_W-1:0] o_a_source,
    output logic [ADDR_W-1:0]   o_a_address,
    output logic [DATA_W/8-1:0] o_a_mask,
    output logic [DATA_W-1:0]   o_a_data,
    input  logic                i_d_valid,
    output logic                o_d_ready,
    input  logic [2:0]          i_d_opcode,
    input  logic [SOURCE_W-1:0] i_d_source,
    input  logic [DATA_W-1:0]   i_d_data,
    input  logic                i_d_error
);

    localparam int BE_W    = DATA_W / 8;
    localparam int SIZE_LG = $clog2(BE_W);
    localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0]    TMO_CNT     = CNT_W'(TIMEOUT);
    localparam logic                TMO_EN      = (TIMEOUT != 0);
    localparam logic [SOURCE_W-1:0] SRC         = SOURCE_W'(SOURCE_ID);
    localparam logic [ADDR_W-1:0]   ADDR_LO_MSK = ADDR_W'(BE_W - 1);

    tlul_state_e         state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                tmo_q, tmo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          d_exp_opcode;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign d_exp_opcode = we_q ? TL_ACCESS_ACK : TL_ACCESS_ACK_DATA;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    be_d    = i_req_be;
                    state_d = ST_A_REQ;
                end
            end
            ST_A_REQ: begin
                if (i_a_ready) begin
                    cnt_d   = '0;
                    state_d = ST_D_WAIT;
                end
            end
            ST_D_WAIT: begin
                // A beat arriving on the deadline cycle still wins over the timeout.
                if (i_d_valid) begin
                    rdata_d = we_q ? '0 : i_d_data;
                    err_d   = i_d_error | (i_d_source != SRC) | (i_d_opcode != d_exp_opcode);
                    tmo_d   = 1'b0;
                    state_d = ST_RSP;
                end else if (TMO_EN && (cnt_q == TMO_CNT)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = ST_RSP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are gated by reset so they read zero for the whole reset window.
    always_comb begin
        o_req_ready   = 1'b0;
        o_d_ready     = 1'b0;
        o_rsp_valid   = 1'b0;
        o_rsp_rdata   = '0;
        o_rsp_err     = 1'b0;
        o_rsp_timeout = 1'b0;
        o_a_valid     = 1'b0;
        o_a_opcode    = 3'd0;
        o_a_param     = 3'd0;
        o_a_size      = 3'd0;
        o_a_source    = '0;
        o_a_address   = '0;
        o_a_mask      = '0;
        o_a_data      = '0;
        if (i_reset_n) begin
            unique case (state_q)
                ST_IDLE: begin
                    o_req_ready = 1'b1;
                    o_d_ready   = 1'b1;
                end
                ST_A_REQ: begin
                    o_a_valid   = 1'b1;
                    o_a_opcode  = a_opcode(we_q, &be_q);
                    o_a_size    = 3'(SIZE_LG);
                    o_a_source  = SRC;
                    o_a_address = addr_q & ~ADDR_LO_MSK;
                    o_a_mask    = we_q ? be_q : '1;
                    o_a_data    = we_q ? wdata_q : '0;
                end
                ST_D_WAIT: begin
                    o_d_ready = 1'b1;
                end
                ST_RSP: begin
                    o_rsp_valid   = 1'b1;
                    o_rsp_rdata   = rdata_q;
                    o_rsp_err     = err_q;
                    o_rsp_timeout = tmo_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tlul_req_master.sv
// Directed bench for tlul_req_master: reads, writes, backpressure, error cases,
// timeout with late-beat drain, D-vs-timeout priority and mid-transfer reset.
module tb_tlul_req_master;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_req_valid, o_req_ready, i_req_we;
    logic [31:0] i_req_addr, i_req_wdata;
    logic [3:0]  i_req_be;
    logic        o_rsp_valid, i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err, o_rsp_timeout;
    logic        o_a_valid, i_a_ready;
    logic [2:0]  o_a_opcode, o_a_param, o_a_size;
    logic [7:0]  o_a_source;
    logic [31:0] o_a_address;
    logic [3:0]  o_a_mask;
    logic [31:0] o_a_data;
    logic        i_d_valid, o_d_ready;
    logic [2:0]  i_d_opcode;
    logic [7:0]  i_d_source;
    logic [31:0] i_d_data;
    logic        i_d_error;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    tlul_req_master #(
        .DATA_W(32), .ADDR_W(32), .SOURCE_W(8), .SOURCE_ID(5), .TIMEOUT(4)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_be(i_req_be),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_err(o_rsp_err), .o_rsp_timeout(o_rsp_timeout),
        .o_a_valid(o_a_valid), .i_a_ready(i_a_ready), .o_a_opcode(o_a_opcode),
        .o_a_param(o_a_param), .o_a_size(o_a_size), .o_a_source(o_a_source),
        .o_a_address(o_a_address), .o_a_mask(o_a_mask), .o_a_data(o_a_data),
        .i_d_valid(i_d_valid), .o_d_ready(o_d_ready), .i_d_opcode(i_d_opcode),
        .i_d_source(i_d_source), .i_d_data(i_d_data), .i_d_error(i_d_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge i_clk);
    endtask

    // Whole transaction from IDLE back to IDLE; i_req_valid stays high throughout
    // so any premature second acceptance would show up as o_req_ready.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int a_wait,
                       input logic [2:0] e_opc, input logic [31:0] e_addr,
                       input logic [3:0] e_mask, input logic [31:0] e_data,
                       input logic [2:0] d_opc, input logic [7:0] d_src, input logic d_err,
                       input logic [31:0] d_data, input int rsp_wait,
                       input logic [31:0] e_rdata, input logic e_err);
        chk({tag, ".req_ready0"}, o_req_ready, 1);
        i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr;
        i_req_wdata = wdata; i_req_be = be;
        cyc();
        i_req_addr = 32'hFFFF_FFFF; i_req_wdata = 32'h5555_5555; i_req_be = 4'h8;
        for (int i = 0; i <= a_wait; i++) begin
            chk({tag, ".a_valid"},   o_a_valid, 1);
            chk({tag, ".a_opcode"},  o_a_opcode, e_opc);
            chk({tag, ".a_address"}, o_a_address, e_addr);
            chk({tag, ".a_mask"},    o_a_mask, e_mask);
            chk({tag, ".a_data"},    o_a_data, e_data);
            chk({tag, ".a_size"},    o_a_size, 2);
            chk({tag, ".a_source"},  o_a_source, 5);
            chk({tag, ".a_param"},   o_a_param, 0);
            chk({tag, ".req_ready_a"}, o_req_ready, 0);
            if (i < a_wait) cyc();
        end
        i_a_ready = 1'b1;
        cyc();
        i_a_ready = 1'b0;
        chk({tag, ".a_valid_off"}, o_a_valid, 0);
        chk({tag, ".d_ready"},     o_d_ready, 1);
        chk({tag, ".rsp_early"},   o_rsp_valid, 0);
        i_d_valid = 1'b1; i_d_opcode = d_opc; i_d_source = d_src;
        i_d_error = d_err; i_d_data = d_data;
        cyc();
        i_d_valid = 1'b0; i_d_error = 1'b0;
        for (int i = 0; i <= rsp_wait; i++) begin
            chk({tag, ".rsp_valid"},   o_rsp_valid, 1);
            chk({tag, ".rsp_rdata"},   o_rsp_rdata, e_rdata);
            chk({tag, ".rsp_err"},     o_rsp_err, e_err);
            chk({tag, ".rsp_timeout"}, o_rsp_timeout, 0);
            chk({tag, ".req_ready_r"}, o_req_ready, 0);
            chk({tag, ".d_ready_r"},   o_d_ready, 0);
            if (i < rsp_wait) cyc();
        end
        i_rsp_ready = 1'b1; i_req_valid = 1'b0;
        cyc();
        i_rsp_ready = 1'b0;
        chk({tag, ".rsp_done"},  o_rsp_valid, 0);
        chk({tag, ".req_ready1"}, o_req_ready, 1);
        $display("txn %s we=%0d addr=%h be=%h rdata=%h err=%0d", tag, we, addr, be, e_rdata, e_err);
    endtask

    // Issue a read and complete its A handshake, leaving the FSM in D_WAIT.
    task automatic start_read(input logic [31:0] addr);
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = addr; i_req_be = 4'h0;
        cyc();
        i_req_valid = 1'b0; i_a_ready = 1'b1;
        cyc();
        i_a_ready = 1'b0;
    endtask

    initial begin
        i_reset_n = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0;
        i_req_wdata = '0; i_req_be = '0; i_rsp_ready = 1'b0; i_a_ready = 1'b0;
        i_d_valid = 1'b0; i_d_opcode = '0; i_d_source = '0; i_d_data = '0; i_d_error = 1'b0;
        repeat (3) cyc();
        chk("rst.req_ready", o_req_ready, 0);
        chk("rst.d_ready",   o_d_ready, 0);
        chk("rst.a_valid",   o_a_valid, 0);
        chk("rst.rsp_valid", o_rsp_valid, 0);
        i_reset_n = 1'b1;
        cyc();
        chk("post_rst.req_ready", o_req_ready, 1);
        chk("post_rst.d_ready",   o_d_ready, 1);

        txn("read", 1'b0, 32'h1003, 32'h0, 4'h0, 0, 3'd4, 32'h1000, 4'hF, 32'h0,
            3'd1, 8'd5, 1'b0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0);
        txn("wr_full", 1'b1, 32'h2004, 32'hCAFEF00D, 4'hF, 0, 3'd0, 32'h2004, 4'hF, 32'hCAFEF00D,
            3'd0, 8'd5, 1'b0, 32'h12345678, 0, 32'h0, 1'b0);
        txn("wr_part", 1'b1, 32'h300A, 32'h0000BEEF, 4'h3, 0, 3'd1, 32'h3008, 4'h3, 32'h0000BEEF,
            3'd0, 8'd5, 1'b0, 32'h0, 0, 32'h0, 1'b0);
        txn("wr_be0", 1'b1, 32'h4000, 32'h11111111, 4'h0, 0, 3'd1, 32'h4000, 4'h0, 32'h11111111,
            3'd0, 8'd5, 1'b0, 32'h0, 0, 32'h0, 1'b0);
        txn("bp", 1'b0, 32'h5001, 32'h0, 4'h0, 5, 3'd4, 32'h5000, 4'hF, 32'h0,
            3'd1, 8'd5, 1'b0, 32'hA5A5A5A5, 3, 32'hA5A5A5A5, 1'b0);
        txn("err_d", 1'b1, 32'h6000, 32'h22222222, 4'hF, 0, 3'd0, 32'h6000, 4'hF, 32'h22222222,
            3'd0, 8'd5, 1'b1, 32'h0, 0, 32'h0, 1'b1);
        txn("err_src", 1'b0, 32'h7000, 32'h0, 4'h0, 0, 3'd4, 32'h7000, 4'hF, 32'h0,
            3'd1, 8'd3, 1'b0, 32'h13572468, 0, 32'h13572468, 1'b1);
        txn("err_opc", 1'b0, 32'h8000, 32'h0, 4'h0, 0, 3'd4, 32'h8000, 4'hF, 32'h0,
            3'd0, 8'd5, 1'b0, 32'h99999999, 0, 32'h99999999, 1'b1);

        // Timeout: five D_WAIT cycles with no beat, then an error response.
        start_read(32'h9000);
        for (int i = 0; i < 5; i++) begin
            chk("tmo.wait_rsp", o_rsp_valid, 0);
            chk("tmo.wait_dready", o_d_ready, 1);
            cyc();
        end
        chk("tmo.rsp_valid", o_rsp_valid, 1);
        chk("tmo.err",       o_rsp_err, 1);
        chk("tmo.timeout",   o_rsp_timeout, 1);
        chk("tmo.rdata",     o_rsp_rdata, 0);
        i_rsp_ready = 1'b1;
        cyc();
        i_rsp_ready = 1'b0;
        chk("tmo.idle", o_req_ready, 1);
        i_d_valid = 1'b1; i_d_opcode = 3'd1; i_d_source = 8'd5; i_d_data = 32'h77777777;
        cyc();
        i_d_valid = 1'b0;
        chk("late.no_rsp",  o_rsp_valid, 0);
        chk("late.idle",    o_req_ready, 1);
        cyc();
        chk("late.no_rsp2", o_rsp_valid, 0);
        $display("txn timeout addr=9000 err=1 timeout=1 late_beat_drained");

        // D beat on the deadline cycle beats the timeout.
        start_read(32'hA000);
        repeat (4) cyc();
        chk("prio.not_yet", o_rsp_valid, 0);
        i_d_valid = 1'b1; i_d_opcode = 3'd1; i_d_source = 8'd5; i_d_data = 32'h0BADCAFE;
        cyc();
        i_d_valid = 1'b0;
        chk("prio.rsp_valid", o_rsp_valid, 1);
        chk("prio.err",       o_rsp_err, 0);
        chk("prio.timeout",   o_rsp_timeout, 0);
        chk("prio.rdata",     o_rsp_rdata, 32'h0BADCAFE);
        i_rsp_ready = 1'b1;
        cyc();
        i_rsp_ready = 1'b0;
        $display("txn priority addr=a000 rdata=0badcafe err=0");

        // Reset while waiting on D, then a stray beat drained in IDLE.
        start_read(32'hB000);
        chk("mid.d_wait", o_d_ready, 1);
        i_reset_n = 1'b0;
        cyc();
        chk("mid.req_ready", o_req_ready, 0);
        chk("mid.d_ready",   o_d_ready, 0);
        chk("mid.a_valid",   o_a_valid, 0);
        chk("mid.rsp_valid", o_rsp_valid, 0);
        chk("mid.rsp_err",   o_rsp_err, 0);
        i_reset_n = 1'b1;
        cyc();
        chk("mid.idle_req",  o_req_ready, 1);
        chk("mid.idle_d",    o_d_ready, 1);
        i_d_valid = 1'b1; i_d_opcode = 3'd1; i_d_source = 8'd5; i_d_data = 32'h44444444;
        cyc();
        i_d_valid = 1'b0;
        chk("mid.stray_rsp", o_rsp_valid, 0);
        chk("mid.stray_idle", o_req_ready, 1);
        $display("txn reset_mid addr=b000 abandoned stray_beat_drained");

        txn("after_rst", 1'b0, 32'hC00F, 32'h0, 4'h0, 0, 3'd4, 32'hC00C, 4'hF, 32'h0,
            3'd1, 8'd5, 1'b0, 32'h600DF00D, 0, 32'h600DF00D, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
